fat32_dir_sector_scanner: RTL and testbench

- Downstream consumer of the SD card controller's read byte stream.
- The FAT32 controller starts it once per directory sector. It parses the 16 × 32-byte directory entries and compares each short (8.3) entry against a target filename and extension.
- It reports the first matching entry's start cluster, size, attribute and index, plus whether the end-of-directory marker was reached.
- The FAT32 controller uses these results to walk the root directory one sector at a time.

---
 rtl/fat32_dir_sector_scanner.sv | 221 ++++++++++++++++++++++
 tb/tb_fat32_dir_sector_scanner.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fat32_dir_sector_scanner.sv
// FAT32 directory sector scanner.
//
// Consumes one 512-byte directory sector from the SD card read byte stream and
// looks for the first short (8.3) entry whose name and extension equal the
// target. Reports that entry's start cluster, size, attribute and index. It also
// flags an end-of-directory marker, which is an entry whose first byte is 0x00.
//
// Ports:
//   clk, rst          rising-edge clock, synchronous active-high reset
//   start             one-cycle pulse arming a scan (honoured only while idle)
//   target_name/ext   8.3 target, sampled on start (byte 0 in the MSBs)
//   byte_valid        byte_in strobe from the SD controller
//   byte_in           sector data byte
//   block_done        sector transfer finished strobe
//   busy              scan in progress
//   done              one-cycle completion pulse
//   match_found       a matching entry was committed this sector
//   end_of_dir        a 0x00 entry start was seen
//   entry_index       index of the matching entry
//   first_cluster     {byte21, byte20, byte27, byte26} of the match
//   file_size         little-endian bytes 28-31 of the match
//   attr              byte 11 of the match
module fat32_dir_sector_scanner #(
    parameter int unsigned MATCH_DIRS         = 0,
    parameter int unsigned ENTRIES_PER_SECTOR = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [63:0] target_name,
    input  logic [23:0] target_ext,
    input  logic        byte_valid,
    input  logic [7:0]  byte_in,
    input  logic        block_done,
    output logic        busy,
    output logic        done,
    output logic        match_found,
    output logic        end_of_dir,
    output logic [3:0]  entry_index,
    output logic [31:0] first_cluster,
    output logic [31:0] file_size,
    output logic [7:0]  attr
);

    localparam logic [9:0] SectorBytes = 10'(ENTRIES_PER_SECTOR * 32);
    localparam logic [9:0] CntMax      = 10'd512;

    typedef enum logic [1:0] {StIdle, StScan, StFinish} state_e;

    state_e      state_q, state_d;
    logic [9:0]  cnt_q, cnt_d;
    logic [87:0] tgt_q, tgt_d;
    logic        mismatch_q, mismatch_d;
    logic        skip_q, skip_d;
    logic [15:0] clus_hi_q, clus_hi_d;
    logic [15:0] clus_lo_q, clus_lo_d;
    logic [31:0] size_sh_q, size_sh_d;
    logic [7:0]  attr_sh_q, attr_sh_d;
    logic        match_found_q, match_found_d;
    logic        end_of_dir_q, end_of_dir_d;
    logic [3:0]  entry_index_q, entry_index_d;
    logic [31:0] first_cluster_q, first_cluster_d;
    logic [31:0] file_size_q, file_size_d;
    logic [7:0]  attr_q, attr_d;

    logic [4:0]  off;
    logic [3:0]  idx;
    logic        take;
    logic [87:0] tgt_shift;
    logic [7:0]  cmp_byte;
    logic        byte_diff;

    assign off = cnt_q[4:0];
    assign idx = cnt_q[8:5];

    // Entries are only evaluated inside the sector window and until the first
    // match or end marker; bytes are still counted afterwards.
    assign take = byte_valid && (cnt_q < SectorBytes) && !match_found_q && !end_of_dir_q;

    // Target byte for the current offset ends up in the top byte (valid for 0-10).
    assign tgt_shift = tgt_q << {off, 3'b000};

    // A stored 0x05 in byte 0 stands for a real leading 0xE5 character.
    assign cmp_byte  = (off == 5'd0 && byte_in == 8'h05) ? 8'hE5 : byte_in;
    assign byte_diff = (cmp_byte != tgt_shift[87:80]);

    always_comb begin
        state_d         = state_q;
        cnt_d           = cnt_q;
        tgt_d           = tgt_q;
        mismatch_d      = mismatch_q;
        skip_d          = skip_q;
        clus_hi_d       = clus_hi_q;
        clus_lo_d       = clus_lo_q;
        size_sh_d       = size_sh_q;
        attr_sh_d       = attr_sh_q;
        match_found_d   = match_found_q;
        end_of_dir_d    = end_of_dir_q;
        entry_index_d   = entry_index_q;
        first_cluster_d = first_cluster_q;
        file_size_d     = file_size_q;
        attr_d          = attr_q;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    tgt_d           = {target_name, target_ext};
                    cnt_d           = '0;
                    mismatch_d      = 1'b0;
                    skip_d          = 1'b0;
                    match_found_d   = 1'b0;
                    end_of_dir_d    = 1'b0;
                    entry_index_d   = '0;
                    first_cluster_d = '0;
                    file_size_d     = '0;
                    attr_d          = '0;
                    state_d         = StScan;
                end
            end

            StScan: begin
                if (byte_valid && cnt_q != CntMax) begin
                    cnt_d = cnt_q + 10'd1;
                end
                if (take) begin
                    // Offset 0 restarts the per-entry flags, discarding any partial entry.
                    if (off == 5'd0) begin
                        if (byte_in == 8'h00) begin
                            end_of_dir_d = 1'b1;
                        end
                        mismatch_d = byte_diff;
                        skip_d     = (byte_in == 8'hE5);
                    end else if (off <= 5'd10) begin
                        mismatch_d = mismatch_q | byte_diff;
                    end

                    case (off)
                        5'd11: begin
                            attr_sh_d = byte_in;
                            if (byte_in == 8'h0F || byte_in[3] ||
                                (byte_in[4] && MATCH_DIRS == 0)) begin
                                skip_d = 1'b1;
                            end
                        end
                        5'd20: clus_hi_d[7:0]   = byte_in;
                        5'd21: clus_hi_d[15:8]  = byte_in;
                        5'd26: clus_lo_d[7:0]   = byte_in;
                        5'd27: clus_lo_d[15:8]  = byte_in;
                        5'd28: size_sh_d[7:0]   = byte_in;
                        5'd29: size_sh_d[15:8]  = byte_in;
                        5'd30: size_sh_d[23:16] = byte_in;
                        5'd31: begin
                            size_sh_d[31:24] = byte_in;
                            if (!mismatch_q && !skip_q) begin
                                match_found_d   = 1'b1;
                                entry_index_d   = idx;
                                first_cluster_d = {clus_hi_q, clus_lo_q};
                                file_size_d     = {byte_in, size_sh_q[23:0]};
                                attr_d          = attr_sh_q;
                            end
                        end
                        default: ;
                    endcase
                end
                if (block_done) begin
                    state_d = StFinish;
                end
            end

            StFinish: state_d = StIdle;

            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= StIdle;
            cnt_q           <= '0;
            tgt_q           <= '0;
            mismatch_q      <= 1'b0;
            skip_q          <= 1'b0;
            clus_hi_q       <= '0;
            clus_lo_q       <= '0;
            size_sh_q       <= '0;
            attr_sh_q       <= '0;
            match_found_q   <= 1'b0;
            end_of_dir_q    <= 1'b0;
            entry_index_q   <= '0;
            first_cluster_q <= '0;
            file_size_q     <= '0;
            attr_q          <= '0;
        end else begin
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            tgt_q           <= tgt_d;
            mismatch_q      <= mismatch_d;
            skip_q          <= skip_d;
            clus_hi_q       <= clus_hi_d;
            clus_lo_q       <= clus_lo_d;
            size_sh_q       <= size_sh_d;
            attr_sh_q       <= attr_sh_d;
            match_found_q   <= match_found_d;
            end_of_dir_q    <= end_of_dir_d;
            entry_index_q   <= entry_index_d;
            first_cluster_q <= first_cluster_d;
            file_size_q     <= file_size_d;
            attr_q          <= attr_d;
        end
    end

    assign busy          = (state_q == StScan);
    assign done          = (state_q == StFinish);
    assign match_found   = match_found_q;
    assign end_of_dir    = end_of_dir_q;
    assign entry_index   = entry_index_q;
    assign first_cluster = first_cluster_q;
    assign file_size     = file_size_q;
    assign attr          = attr_q;

endmodule

// File: tb/tb_fat32_dir_sector_scanner.sv
// Directed bench for fat32_dir_sector_scanner: builds sectors in memory, streams
// them in and compares the reported results against hand-computed values.
module tb_fat32_dir_sector_scanner;

    logic        clk;
    logic        rst;
    logic        start;
    logic [63:0] target_name;
    logic [23:0] target_ext;
    logic        byte_valid;
    logic [7:0]  byte_in;
    logic        block_done;
    logic        busy;
    logic        done;
    logic        match_found;
    logic        end_of_dir;
    logic [3:0]  entry_index;
    logic [31:0] first_cluster;
    logic [31:0] file_size;
    logic [7:0]  attr;

    int checks;
    int errors;

    logic [7:0] sec [512];

    localparam logic [87:0] Readme = "README  TXT";
    localparam logic [87:0] Other  = "OTHER   BIN";
    localparam logic [87:0] Filler = "FILLER  DAT";

    fat32_dir_sector_scanner #(
        .MATCH_DIRS         (0),
        .ENTRIES_PER_SECTOR (16)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .target_name   (target_name),
        .target_ext    (target_ext),
        .byte_valid    (byte_valid),
        .byte_in       (byte_in),
        .block_done    (block_done),
        .busy          (busy),
        .done          (done),
        .match_found   (match_found),
        .end_of_dir    (end_of_dir),
        .entry_index   (entry_index),
        .first_cluster (first_cluster),
        .file_size     (file_size),
        .attr          (attr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_result(input string tag, input logic mf, input logic eod,
                                input logic [3:0] idx, input logic [31:0] cl,
                                input logic [31:0] sz, input logic [7:0] at);
        check({tag, "_match"}, {31'd0, match_found}, {31'd0, mf});
        check({tag, "_eod"},   {31'd0, end_of_dir},  {31'd0, eod});
        check({tag, "_idx"},   {28'd0, entry_index}, {28'd0, idx});
        check({tag, "_clus"},  first_cluster, cl);
        check({tag, "_size"},  file_size, sz);
        check({tag, "_attr"},  {24'd0, attr}, {24'd0, at});
    endtask

    task automatic set_entry(input int e, input logic [87:0] nm, input logic [7:0] at,
                             input logic [15:0] hi, input logic [15:0] lo,
                             input logic [31:0] sz);
        logic [87:0] sh;
        int b;
        b = e * 32;
        for (int k = 0; k < 32; k++) sec[b + k] = 8'h00;
        for (int k = 0; k < 11; k++) begin
            sh = nm << (8 * k);
            sec[b + k] = sh[87:80];
        end
        sec[b + 11] = at;
        sec[b + 20] = hi[7:0];
        sec[b + 21] = hi[15:8];
        sec[b + 26] = lo[7:0];
        sec[b + 27] = lo[15:8];
        sec[b + 28] = sz[7:0];
        sec[b + 29] = sz[15:8];
        sec[b + 30] = sz[23:16];
        sec[b + 31] = sz[31:24];
    endtask

    task automatic fill_default();
        for (int e = 0; e < 16; e++) begin
            set_entry(e, Filler, 8'h20, 16'(e), 16'(e), 32'(e));
        end
    endtask

    task automatic pulse_start(input logic [87:0] tgt);
        target_name = tgt[87:24];
        target_ext  = tgt[23:0];
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic send_bytes(input int from, input int to, input bit done_last);
        for (int i = from; i < to; i++) begin
            byte_valid = 1'b1;
            byte_in    = sec[i];
            block_done = done_last && (i == to - 1);
            @(posedge clk); #1;
        end
        byte_valid = 1'b0;
        block_done = 1'b0;
    endtask

    // Called one edge after block_done was sampled: done must be up exactly now.
    task automatic check_done(input string tag);
        check({tag, "_done"}, {31'd0, done}, 32'd1);
        check({tag, "_busy_fin"}, {31'd0, busy}, 32'd0);
        @(posedge clk); #1;
        check({tag, "_done_low"}, {31'd0, done}, 32'd0);
    endtask

    task automatic end_block(input string tag);
        block_done = 1'b1;
        @(posedge clk); #1;
        block_done = 1'b0;
        check_done(tag);
    endtask

    task automatic full_scan(input string tag, input logic [87:0] tgt);
        pulse_start(tgt);
        check({tag, "_busy"}, {31'd0, busy}, 32'd1);
        send_bytes(0, 512, 1'b0);
        end_block(tag);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        start = 1'b0;
        target_name = '0;
        target_ext = '0;
        byte_valid = 1'b0;
        byte_in = '0;
        block_done = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check_result("rst", 1'b0, 1'b0, 4'd0, 32'd0, 32'd0, 8'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Basic match at entry 3.
        fill_default();
        set_entry(3, Readme, 8'h20, 16'h0001, 16'h0005, 32'h0000_1234);
        full_scan("m3", Readme);
        check_result("m3", 1'b1, 1'b0, 4'd3, 32'h0001_0005, 32'h0000_1234, 8'h20);
        @(posedge clk); #1;
        check("m3_hold", first_cluster, 32'h0001_0005);

        // Deleted, LFN, volume label and directory entries are skipped.
        fill_default();
        set_entry(0, Readme, 8'h20, 16'h0, 16'h0010, 32'h1);
        sec[0] = 8'hE5;
        set_entry(1, Readme, 8'h0F, 16'h0, 16'h0011, 32'h2);
        set_entry(2, Readme, 8'h08, 16'h0, 16'h0012, 32'h3);
        set_entry(4, Readme, 8'h10, 16'h0, 16'h0014, 32'h4);
        set_entry(5, Readme, 8'h20, 16'h0002, 16'h0300, 32'h00AB_CDEF);
        full_scan("skip", Readme);
        check_result("skip", 1'b1, 1'b0, 4'd5, 32'h0002_0300, 32'h00AB_CDEF, 8'h20);

        // Directory only: no match with MATCH_DIRS = 0.
        fill_default();
        set_entry(6, Readme, 8'h10, 16'h0, 16'h0006, 32'h0);
        full_scan("dir", Readme);
        check_result("dir", 1'b0, 1'b0, 4'd0, 32'd0, 32'd0, 8'd0);

        // End marker at entry 4 hides the match at entry 6.
        fill_default();
        sec[128] = 8'h00;
        set_entry(6, Readme, 8'h20, 16'h0, 16'h0006, 32'h6);
        full_scan("eod", Readme);
        check_result("eod", 1'b0, 1'b1, 4'd0, 32'd0, 32'd0, 8'd0);

        // Stored 0x05 matches a target starting with 0xE5.
        fill_default();
        set_entry(7, {8'hE5, "ABCDEF DAT"}, 8'h00, 16'h0000, 16'h0077, 32'h0000_0700);
        sec[224] = 8'h05;
        full_scan("e5", {8'hE5, "ABCDEF DAT"});
        check_result("e5", 1'b1, 1'b0, 4'd7, 32'h0000_0077, 32'h0000_0700, 8'h00);

        // First of two matches wins.
        fill_default();
        set_entry(2, Readme, 8'h21, 16'h0, 16'h0022, 32'h0000_0200);
        set_entry(9, Readme, 8'h20, 16'h0, 16'h0099, 32'h0000_0900);
        full_scan("first", Readme);
        check_result("first", 1'b1, 1'b0, 4'd2, 32'h0000_0022, 32'h0000_0200, 8'h21);

        // Last byte coincides with block_done; entry 15 still commits.
        fill_default();
        set_entry(15, Readme, 8'h01, 16'hFFFF, 16'h0FFF, 32'hFFFF_FFFF);
        pulse_start(Readme);
        send_bytes(0, 512, 1'b1);
        check_done("last");
        check_result("last", 1'b1, 1'b0, 4'd15, 32'hFFFF_0FFF, 32'hFFFF_FFFF, 8'h01);

        // Short block: partial entry 3 is discarded.
        fill_default();
        set_entry(3, Readme, 8'h20, 16'h0001, 16'h0005, 32'h0000_1234);
        pulse_start(Readme);
        send_bytes(0, 100, 1'b0);
        end_block("short");
        check_result("short", 1'b0, 1'b0, 4'd0, 32'd0, 32'd0, 8'd0);

        // start while busy is ignored.
        fill_default();
        set_entry(3, Readme, 8'h20, 16'h0001, 16'h0005, 32'h0000_1234);
        pulse_start(Readme);
        send_bytes(0, 50, 1'b0);
        pulse_start(Other);
        check("busy_start_busy", {31'd0, busy}, 32'd1);
        send_bytes(50, 512, 1'b0);
        end_block("bstart");
        check_result("bstart", 1'b1, 1'b0, 4'd3, 32'h0001_0005, 32'h0000_1234, 8'h20);

        // Reset mid-scan aborts without done, then a fresh scan works.
        fill_default();
        set_entry(3, Readme, 8'h20, 16'h0001, 16'h0005, 32'h0000_1234);
        pulse_start(Readme);
        send_bytes(0, 200, 1'b0);
        check("pre_rst_match", {31'd0, match_found}, 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("mrst_busy", {31'd0, busy}, 32'd0);
        check("mrst_done", {31'd0, done}, 32'd0);
        check_result("mrst", 1'b0, 1'b0, 4'd0, 32'd0, 32'd0, 8'd0);
        repeat (2) begin
            @(posedge clk); #1;
            check("mrst_no_done", {31'd0, done}, 32'd0);
        end
        fill_default();
        set_entry(5, Readme, 8'h20, 16'h0002, 16'h0300, 32'h0000_5555);
        full_scan("after", Readme);
        check_result("after", 1'b1, 1'b0, 4'd5, 32'h0002_0300, 32'h0000_5555, 8'h20);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
